bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that sits directly upstream of `mmapper`, in place of the direct `pa/pd/pwe/prd` connection. Master 0 is the CPU/MMU physical port and master 1 is a DMA-capable peripheral port. The arbiter serialises both masters onto the single `mmapper` request/ready bus. It also bounds every transaction with a timeout, so a slave that never answers cannot hang the system.

---
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises two masters (m0 = CPU/MMU, m1 = DMA peripheral)
// onto the single mmapper request/ready bus. Every grant is bounded by a
// timeout, so a slave that never answers completes with ERR_DATA and an err pulse.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> ties alternate between masters using a 1-bit last-grant pointer
//   undefined -> fixed priority, m1 wins ties (no pointer logic)
//
// State table:
//   ST_IDLE | no grant, slave bus driven to zero, requests are arbitrated
//   ST_GNT0 | m0 owns the slave bus; response forwarded to m0
//   ST_GNT1 | m1 owns the slave bus; response forwarded to m1

module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic        err,
    output logic [31:0] err_a,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    // Counter value seen in the last grant cycle before forced completion.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] err_a_q, err_a_d;

    logic        req0, req1;
    logic        pick_m1;

    // Granted-master view, selected by current state.
    logic        sel_m1;
    logic [31:0] g_a, g_d;
    logic        g_we, g_rd, g_req;

    assign req0   = m0_rd | m0_we;
    assign req1   = m1_rd | m1_we;
    assign sel_m1 = (state_q == ST_GNT1);
    assign g_a    = sel_m1 ? m1_a  : m0_a;
    assign g_d    = sel_m1 ? m1_d  : m0_d;
    assign g_we   = sel_m1 ? m1_we : m0_we;
    assign g_rd   = sel_m1 ? m1_rd : m0_rd;
    assign g_req  = g_rd | g_we;
    assign err_a  = err_a_q;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = m1 was granted last; reset value favours m0 on the first tie.
    logic last_m1_q, last_m1_d;

    assign pick_m1 = req1 & (~req0 | ~last_m1_q);

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_m1_q <= 1'b1;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end

    // Pointer follows every grant decision made in IDLE.
    always_comb begin
        last_m1_d = last_m1_q;
        if (state_q == ST_IDLE && (req0 | req1)) begin
            last_m1_d = pick_m1;
        end
    end
`else
    assign pick_m1 = req1;
`endif

    // State, timeout counter and captured error address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            err_a_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_a_q <= err_a_d;
        end
    end

    // Next-state decode and combinational slave/master routing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_a_d  = err_a_q;
        s_a      = 32'd0;
        s_d      = 32'd0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_ready = 1'b0;
        m0_spo   = 32'd0;
        m1_ready = 1'b0;
        m1_spo   = 32'd0;
        err      = 1'b0;
        gnt      = 2'b00;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (req0 | req1) begin
                    state_d = pick_m1 ? ST_GNT1 : ST_GNT0;
                end
            end

            ST_GNT0, ST_GNT1: begin
                s_a  = g_a;
                s_d  = g_d;
                s_we = g_we;
                s_rd = g_rd;
                gnt  = sel_m1 ? 2'b10 : 2'b01;
                if (sel_m1) begin
                    m1_spo = s_spo;
                end else begin
                    m0_spo = s_spo;
                end

                if (!g_req) begin
                    // Master withdrew mid-transaction: release silently.
                    state_d = ST_IDLE;
                end else if (s_ready) begin
                    // A real answer wins over a coincident timeout.
                    state_d = ST_IDLE;
                    if (sel_m1) begin
                        m1_ready = 1'b1;
                    end else begin
                        m0_ready = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err     = 1'b1;
                    err_a_d = g_a;
                    if (sel_m1) begin
                        m1_ready = 1'b1;
                        m1_spo   = ERR_DATA;
                    end else begin
                        m0_ready = 1'b1;
                        m0_spo   = ERR_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then
// randomized masters/slave checked every cycle against a transaction-level model.

module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m1_a, m1_d;
    logic        m0_we, m0_rd, m1_we, m1_rd;
    logic [31:0] m0_spo, m1_spo;
    logic        m0_ready, m1_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic        s_we, s_rd, s_ready;
    logic        err;
    logic [31:0] err_a;
    logic [1:0]  gnt;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
        .s_spo(s_spo), .s_ready(s_ready),
        .err(err), .err_a(err_a), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 idle, 0 or 1 granted master; gcycle counts grant cycles from 1.
    int          mdl_owner = -1;
    int          mdl_gcycle = 0;
    int          mdl_last = 1;
    logic [31:0] mdl_err_a = 32'd0;
    bit          chk_en = 1'b0;
    bit          ready_seen [2];

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] in_a [2];
            logic [31:0] in_d [2];
            logic        in_we [2];
            logic        in_rd [2];
            logic        req [2];
            logic [31:0] e_sa, e_sd, e_spo [2];
            logic        e_swe, e_srd, e_err;
            logic        e_rdy [2];
            logic [1:0]  e_gnt;
            int          nxt_owner;

            in_a[0] = m0_a;  in_d[0] = m0_d;  in_we[0] = m0_we;  in_rd[0] = m0_rd;
            in_a[1] = m1_a;  in_d[1] = m1_d;  in_we[1] = m1_we;  in_rd[1] = m1_rd;
            req[0] = m0_rd | m0_we;
            req[1] = m1_rd | m1_we;
            e_sa = 0; e_sd = 0; e_swe = 0; e_srd = 0; e_err = 0; e_gnt = 2'b00;
            e_spo[0] = 0; e_spo[1] = 0; e_rdy[0] = 0; e_rdy[1] = 0;
            nxt_owner = mdl_owner;

            if (mdl_owner < 0) begin
                if (req[0] || req[1]) begin
                    if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                        nxt_owner = (mdl_last == 1) ? 0 : 1;
`else
                        nxt_owner = 1;
`endif
                    end else begin
                        nxt_owner = req[1] ? 1 : 0;
                    end
                    mdl_last   = nxt_owner;
                    mdl_gcycle = 1;
                end
            end else begin
                e_sa  = in_a[mdl_owner];
                e_sd  = in_d[mdl_owner];
                e_swe = in_we[mdl_owner];
                e_srd = in_rd[mdl_owner];
                e_gnt = (mdl_owner == 1) ? 2'b10 : 2'b01;
                e_spo[mdl_owner] = s_spo;
                if (!req[mdl_owner]) begin
                    nxt_owner = -1;
                end else if (s_ready) begin
                    e_rdy[mdl_owner] = 1'b1;
                    nxt_owner = -1;
                end else if (mdl_gcycle == TO) begin
                    e_rdy[mdl_owner] = 1'b1;
                    e_spo[mdl_owner] = 32'hFFFF_FFFF;
                    e_err = 1'b1;
                    nxt_owner = -1;
                end else begin
                    mdl_gcycle++;
                end
            end

            chk("s_a", s_a, e_sa);
            chk("s_d", s_d, e_sd);
            chk("ctrl{s_we,s_rd,gnt,err,m0_ready,m1_ready}",
                {25'd0, s_we, s_rd, gnt, err, m0_ready, m1_ready},
                {25'd0, e_swe, e_srd, e_gnt, e_err, e_rdy[0], e_rdy[1]});
            chk("m0_spo", m0_spo, e_spo[0]);
            chk("m1_spo", m1_spo, e_spo[1]);
            chk("err_a", err_a, mdl_err_a);

            if (e_err) mdl_err_a = in_a[mdl_owner];
            ready_seen[0] = e_rdy[0];
            ready_seen[1] = e_rdy[1];
            mdl_owner = nxt_owner;

            if (rst) begin
                mdl_owner  = -1;
                mdl_gcycle = 0;
                mdl_last   = 1;
                mdl_err_a  = 32'd0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] exp_tie [8];
    logic [1:0] exp_after_rst;
    bit         act [2];

    task automatic clear_masters();
        m0_a = 0; m0_d = 0; m0_we = 0; m0_rd = 0;
        m1_a = 0; m1_d = 0; m1_we = 0; m1_rd = 0;
    endtask

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        exp_after_rst = 2'b01;
`else
        exp_tie = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        exp_after_rst = 2'b10;
`endif
        rst = 1'b1;
        clear_masters();
        s_spo = 0; s_ready = 0;
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset gnt", {30'd0, gnt}, 32'd0);
        chk("reset err_a", err_a, 32'd0);
        chk("reset ready/err", {29'd0, m0_ready, m1_ready, err}, 32'd0);
        tick();
        rst = 1'b0;

        // Single read from m0, slave answers on grant cycle 3.
        tick();
        m0_rd = 1; m0_a = 32'h2000_0010;
        @(negedge clk); chk("read idle s_rd", {31'd0, s_rd}, 32'd0);
        tick();
        @(negedge clk); chk("read gc1 s_rd", {31'd0, s_rd}, 32'd1);
        chk("read gc1 s_a", s_a, 32'h2000_0010);
        tick();
        @(negedge clk); chk("read gc2 m0_ready", {31'd0, m0_ready}, 32'd0);
        tick();
        s_ready = 1; s_spo = 32'h1234_5678;
        @(negedge clk); chk("read gc3 m0_ready", {31'd0, m0_ready}, 32'd1);
        chk("read gc3 m0_spo", m0_spo, 32'h1234_5678);
        tick();
        m0_rd = 0; s_ready = 0; s_spo = 0;
        @(negedge clk); chk("read after s_rd", {31'd0, s_rd}, 32'd0);

        // Timeout on an m1 write.
        tick();
        m1_we = 1; m1_a = 32'h9600_0000; m1_d = 32'h0000_00AA;
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            if (i < 4) chk("timeout early ready", {30'd0, m1_ready, err}, 32'd0);
        end
        chk("timeout m1_ready", {31'd0, m1_ready}, 32'd1);
        chk("timeout m1_spo", m1_spo, 32'hFFFF_FFFF);
        chk("timeout err", {31'd0, err}, 32'd1);
        tick();
        m1_we = 0;
        @(negedge clk); chk("timeout err_a", err_a, 32'h9600_0000);
        chk("timeout then idle", {30'd0, gnt}, 32'd0);

        // s_ready coincides with the timeout cycle.
        tick();
        m0_rd = 1; m0_a = 32'h0000_4000;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 4) begin s_ready = 1; s_spo = 32'hA5A5_0001; end
        end
        @(negedge clk); chk("collide m0_ready", {31'd0, m0_ready}, 32'd1);
        chk("collide m0_spo", m0_spo, 32'hA5A5_0001);
        chk("collide err", {31'd0, err}, 32'd0);
        tick();
        m0_rd = 0; s_ready = 0; s_spo = 0;
        @(negedge clk); chk("collide err_a kept", err_a, 32'h9600_0000);

        // Reset in the middle of an m0 read.
        tick();
        m0_rd = 1; m0_a = 32'h2000_0020;
        tick();
        tick();
        rst = 1; m1_rd = 1; m1_a = 32'h3000_0000;
        @(negedge clk); chk("midrst gc2 gnt", {30'd0, gnt}, 32'd1);
        tick();
        rst = 0;
        @(negedge clk); chk("midrst s_rd", {31'd0, s_rd}, 32'd0);
        chk("midrst gnt", {30'd0, gnt}, 32'd0);
        chk("midrst m0_ready", {31'd0, m0_ready}, 32'd0);
        chk("midrst err_a", err_a, 32'd0);
        tick();
        @(negedge clk); chk("midrst first grant", {30'd0, gnt}, {30'd0, exp_after_rst});
        tick();
        clear_masters();
        tick();

        // Tie: both masters request continuously, slave answers immediately.
        rst = 1; m0_rd = 1; m1_rd = 1; m0_a = 32'h10; m1_a = 32'h20; s_ready = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tie gnt order", {30'd0, gnt}, {30'd0, exp_tie[i]});
            tick();
        end
        m1_rd = 0;
        @(negedge clk); chk("tie m1 drop idle", {30'd0, gnt}, 32'd0);
        tick();
        @(negedge clk); chk("tie m0 after m1 drop", {30'd0, gnt}, 32'd1);
        tick();
        clear_masters(); s_ready = 0;
        tick();

        // Randomized traffic; masters hold requests until they see ready.
        act[0] = 0; act[1] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] na, nd;
                logic [1:0]  kind;
                if (act[k] && ready_seen[k]) act[k] = 0;
                if (act[k] && $urandom_range(99) < 3) begin
                    act[k] = 0;
                end else if (!act[k] && $urandom_range(1) == 1) begin
                    act[k] = 1;
                    na = $urandom; nd = $urandom;
                    kind = 2'($urandom_range(2, 1) + (($urandom_range(9) == 0) ? 1 : 0));
                    if (k == 0) begin m0_a = na; m0_d = nd; {m0_we, m0_rd} = kind; end
                    else        begin m1_a = na; m1_d = nd; {m1_we, m1_rd} = kind; end
                end
                if (!act[k]) begin
                    if (k == 0) begin m0_we = 0; m0_rd = 0; end
                    else        begin m1_we = 0; m1_rd = 0; end
                end
            end
            s_spo   = $urandom;
            s_ready = ($urandom_range(9) < 3);
            rst     = ($urandom_range(499) == 0);
            if (rst) begin act[0] = 0; act[1] = 0; end
            tick();
        end
        rst = 0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
